usb_bluejay_line_streamer: RTL and testbench

Parametrised successor to the USB-to-Bluejay interface. Drains 32-bit (generically DATA_W) words from the show-ahead USB receive FIFO and streams them to the Bluejay SLM as line-framed bursts, under a word/line/frame counter FSM. Adds configurable line geometry, a post-line gap, stall handling and underrun detection. Sits between the FT601 receive FIFO and the Bluejay display-data port.

---
 rtl/usb_bluejay_pkg.sv | 21 ++
 rtl/bluejay_geom_counter.sv | 45 ++++
 rtl/usb_bluejay_line_streamer.sv | 142 ++++++++++++++
 tb/tb_usb_bluejay_line_streamer.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_bluejay_pkg.sv
// usb_bluejay_pkg
// Shared state encoding, default line geometry and counter-width helper.
package usb_bluejay_pkg;

    localparam int DEF_DATA_W          = 32;
    localparam int DEF_WORDS_PER_LINE  = 40;
    localparam int DEF_LINES_PER_FRAME = 1024;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        STREAM    = 2'd2,
        GAP       = 2'd3
    } lstate_e;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bluejay_geom_counter.sv
// bluejay_geom_counter
// Word-in-line and line-in-frame counters with terminal flags.
module bluejay_geom_counter
    import usb_bluejay_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    localparam int WW = cnt_w(WORDS_PER_LINE),
    localparam int LW = cnt_w(LINES_PER_FRAME)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          word_inc,
    input  logic          word_clr,
    input  logic          line_inc,
    input  logic          line_clr,
    output logic [WW-1:0] word_cnt,
    output logic [LW-1:0] line_cnt,
    output logic          last_word,
    output logic          last_line
);

    localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_LINE - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINES_PER_FRAME - 1);

    assign last_word = (word_cnt == WORD_LAST);
    assign last_line = (line_cnt == LINE_LAST);

    // Word counter: clear has priority, increment holds at the terminal value.
    always_ff @(posedge clk) begin
        if (reset || word_clr)
            word_cnt <= '0;
        else if (word_inc && !last_word)
            word_cnt <= word_cnt + WW'(1);
    end

    // Line counter: same rules as the word counter.
    always_ff @(posedge clk) begin
        if (reset || line_clr)
            line_cnt <= '0;
        else if (line_inc && !last_line)
            line_cnt <= line_cnt + LW'(1);
    end

endmodule

// File: rtl/usb_bluejay_line_streamer.sv
// usb_bluejay_line_streamer
// Drains the show-ahead USB FIFO into line-framed Bluejay bursts.
module usb_bluejay_line_streamer
    import usb_bluejay_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int LINE_GAP        = 4,
    parameter int STALL_LIMIT     = 16,
    localparam int LW = cnt_w(LINES_PER_FRAME)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              fifo_empty_i,
    output logic              fifo_output_enable_o,
    output logic              get_next_word_o,
    input  logic              next_frame_rdy_i,
    input  logic              next_line_rdy_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic              line_start_o,
    output logic              line_end_o,
    output logic              frame_end_o,
    output logic [LW-1:0]     line_count_o,
    output logic              underrun_o,
    output logic              busy_o
);

    localparam int WW = cnt_w(WORDS_PER_LINE);
    localparam int GW = cnt_w(LINE_GAP + 1);
    localparam int SW = cnt_w(STALL_LIMIT + 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
    localparam logic [SW-1:0] STALL_TRIP = SW'(STALL_LIMIT - 1);
    localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_LIMIT);

    lstate_e       state;
    logic [GW-1:0] gap_cnt;
    logic [SW-1:0] stall_cnt;
    logic [WW-1:0] word_cnt;
    logic          last_word;
    logic          last_line;
    logic          pop;
    logic          line_done;
    logic          frame_go;

    // Pop must react to the FIFO flag in the same cycle, so it stays combinational.
    assign pop       = (state == STREAM) && !fifo_empty_i && !reset_i;
    assign line_done = pop && last_word;
    assign frame_go  = (state == IDLE) && next_frame_rdy_i;

    assign get_next_word_o      = pop;
    assign fifo_output_enable_o = (state == WAIT_LINE) || (state == STREAM);
    assign busy_o               = (state != IDLE);

    bluejay_geom_counter #(
        .WORDS_PER_LINE  (WORDS_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME)
    ) u_geom (
        .clk       (clk_i),
        .reset     (reset_i),
        .word_inc  (pop && !last_word),
        .word_clr  (line_done || frame_go),
        .line_inc  (line_done && !last_line),
        .line_clr  (frame_go),
        .word_cnt  (word_cnt),
        .line_cnt  (line_count_o),
        .last_word (last_word),
        .last_line (last_line)
    );

    // Frame/line sequencing: wait for the sink, stream one line, then idle gap.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (next_frame_rdy_i)
                        state <= WAIT_LINE;
                end
                WAIT_LINE: begin
                    if (next_line_rdy_i && !fifo_empty_i)
                        state <= STREAM;
                end
                STREAM: begin
                    if (line_done) begin
                        gap_cnt <= '0;
                        if (last_line)
                            state <= IDLE;
                        else if (LINE_GAP == 0)
                            state <= WAIT_LINE;
                        else
                            state <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= WAIT_LINE;
                    else
                        gap_cnt <= gap_cnt + GW'(1);
                end
            endcase
        end
    end

    // Count consecutive starved cycles inside a line; underrun is sticky.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt  <= '0;
            underrun_o <= 1'b0;
        end else if (state != STREAM || pop) begin
            stall_cnt <= '0;
        end else begin
            if (stall_cnt != STALL_MAX)
                stall_cnt <= stall_cnt + SW'(1);
            if (stall_cnt == STALL_TRIP)
                underrun_o <= 1'b1;
        end
    end

    // Output stage: popped word and its framing flags appear one cycle later.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            line_start_o <= 1'b0;
            line_end_o   <= 1'b0;
            frame_end_o  <= 1'b0;
        end else begin
            data_valid_o <= pop;
            line_start_o <= pop && (word_cnt == '0);
            line_end_o   <= line_done;
            frame_end_o  <= line_done && last_line;
            if (pop)
                data_o <= data_i;
        end
    end

endmodule

// File: tb/tb_usb_bluejay_line_streamer.sv
// tb_usb_bluejay_line_streamer
// Queue-modelled FIFO and expected stream, randomised data and stalls.
`timescale 1ns/1ps
module tb_usb_bluejay_line_streamer;

    localparam int DW    = 32;
    localparam int WPL   = 4;
    localparam int LPF   = 3;
    localparam int GAPC  = 2;
    localparam int STALL = 8;
    localparam int FW    = WPL * LPF;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [DW-1:0] data_i = '0;
    logic          fifo_empty_i = 1'b1;
    logic          next_frame_rdy_i = 1'b0;
    logic          next_line_rdy_i = 1'b0;
    logic          fifo_output_enable_o, get_next_word_o;
    logic          data_valid_o, line_start_o, line_end_o, frame_end_o;
    logic          underrun_o, busy_o;
    logic [DW-1:0] data_o;
    logic [1:0]    line_count_o;

    typedef struct {
        logic [DW-1:0] d;
        logic          ls;
        logic          le;
        logic          fe;
        logic [1:0]    lc;
        int            cyc;
    } beat_t;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sent_q[$];
    beat_t         beats[$];

    int cyc = 0, npops = 0, hold_empty = 0, stall_at = -1, stall_len = 0;
    int pop_no_oe = 0, pop_empty = 0, pop_reset = 0;
    bit rand_stall = 1'b0;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    usb_bluejay_line_streamer #(
        .DATA_W          (DW),
        .WORDS_PER_LINE  (WPL),
        .LINES_PER_FRAME (LPF),
        .LINE_GAP        (GAPC),
        .STALL_LIMIT     (STALL)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .data_i               (data_i),
        .fifo_empty_i         (fifo_empty_i),
        .fifo_output_enable_o (fifo_output_enable_o),
        .get_next_word_o      (get_next_word_o),
        .next_frame_rdy_i     (next_frame_rdy_i),
        .next_line_rdy_i      (next_line_rdy_i),
        .data_o               (data_o),
        .data_valid_o         (data_valid_o),
        .line_start_o         (line_start_o),
        .line_end_o           (line_end_o),
        .frame_end_o          (frame_end_o),
        .line_count_o         (line_count_o),
        .underrun_o           (underrun_o),
        .busy_o               (busy_o)
    );

    task automatic drive_fifo();
        if (rand_stall && hold_empty == 0 && !fifo_empty_i &&
            $urandom_range(0, 3) == 0)
            hold_empty = $urandom_range(1, 5);
        if (hold_empty > 0) begin
            fifo_empty_i = 1'b1;
            hold_empty--;
        end else begin
            fifo_empty_i = (fifo_q.size() == 0);
        end
        data_i = fifo_empty_i ? DW'($urandom) : fifo_q[0];
    endtask

    task automatic fill(input int n, input bit rnd,
                        input logic [DW-1:0] base, input bit clr);
        logic [DW-1:0] w;
        if (clr) begin
            fifo_q.delete();
            sent_q.delete();
            beats.delete();
        end
        for (int i = 0; i < n; i++) begin
            w = rnd ? DW'($urandom) : base + DW'(i);
            fifo_q.push_back(w);
            sent_q.push_back(w);
        end
        drive_fifo();
    endtask

    task automatic step();
        bit popped;
        @(negedge clk);
        popped = get_next_word_o;
        if (popped && !fifo_output_enable_o) pop_no_oe++;
        if (popped && fifo_empty_i) pop_empty++;
        if (popped && reset_i) pop_reset++;
        @(posedge clk);
        #1;
        cyc++;
        if (popped && !fifo_empty_i && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            npops++;
        end
        if (data_valid_o)
            beats.push_back('{data_o, line_start_o, line_end_o,
                              frame_end_o, line_count_o, cyc});
        if (popped && npops == stall_at)
            hold_empty = stall_len;
        drive_fifo();
    endtask

    task automatic run_beats(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (beats.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (beats.size() >= n);
    endtask

    task automatic do_reset();
        next_frame_rdy_i = 1'b0;
        next_line_rdy_i  = 1'b0;
        rand_stall = 1'b0;
        stall_at   = -1;
        hold_empty = 0;
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
    endtask

    task automatic start_frame();
        next_frame_rdy_i = 1'b1;
        step();
        next_frame_rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] ctl;
        fill(8, 1'b1, '0, 1'b1);
        do_reset();
        ctl = {fifo_output_enable_o, get_next_word_o, data_valid_o,
               line_start_o, line_end_o, frame_end_o, underrun_o, busy_o};
        checks++;
        if (ctl !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctl got=%b want=00000000", ctl);
        end
        checks++;
        if (data_o !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", data_o);
        end
        checks++;
        if (line_count_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_line got=%0d want=0", line_count_o);
        end
    endtask

    task automatic test_frame();
        bit ok;
        int d;
        fill(FW, 1'b0, 32'h100, 1'b1);
        next_line_rdy_i = 1'b1;
        start_frame();
        run_beats(FW, 200, ok);
        checks++;
        if (!ok || beats.size() != FW) begin
            failures++;
            $display("FAIL frame_beats got=%0d want=%0d", beats.size(), FW);
        end
        for (int k = 0; k < beats.size(); k++) begin
            checks++;
            if ({beats[k].d, beats[k].ls, beats[k].le, beats[k].fe} !==
                {sent_q[k], ((k % WPL) == 0), ((k % WPL) == WPL - 1),
                 ((k % FW) == FW - 1)}) begin
                failures++;
                $display("FAIL frame_beat%0d got=%h/%b%b%b want=%h/%b%b%b",
                         k, beats[k].d, beats[k].ls, beats[k].le,
                         beats[k].fe, sent_q[k], (k % WPL) == 0,
                         (k % WPL) == WPL - 1, (k % FW) == FW - 1);
            end
            if (k % WPL == 0) begin
                checks++;
                if (beats[k].lc !== 2'((k / WPL) % LPF)) begin
                    failures++;
                    $display("FAIL frame_lc%0d got=%0d want=%0d",
                             k, beats[k].lc, (k / WPL) % LPF);
                end
            end
            if (k > 0) begin
                d = beats[k].cyc - beats[k-1].cyc;
                checks++;
                if ((k % WPL == 0) ? (d < GAPC + 2) : (d != 1)) begin
                    failures++;
                    $display("FAIL frame_spacing%0d got=%0d want=%s", k, d,
                             (k % WPL == 0) ? ">=4" : "1");
                end
            end
        end
        checks++;
        if ({busy_o, underrun_o} !== 2'b00) begin
            failures++;
            $display("FAIL frame_idle got=%b want=00", {busy_o, underrun_o});
        end
    endtask

    task automatic test_short_stall();
        bit ok;
        int bad;
        do_reset();
        fill(FW, 1'b1, '0, 1'b1);
        stall_at  = npops + 2;
        stall_len = 3;
        next_line_rdy_i = 1'b1;
        start_frame();
        run_beats(FW, 300, ok);
        bad = ok ? 0 : 1;
        for (int k = 0; k < beats.size(); k++)
            if (beats[k].d !== sent_q[k]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_order got=%0d bad want=0", bad);
        end
        checks++;
        if (!ok || beats[2].cyc - beats[1].cyc != 4) begin
            failures++;
            $display("FAIL stall_hole got=%0d want=4",
                     ok ? beats[2].cyc - beats[1].cyc : -1);
        end
        checks++;
        if (underrun_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_underrun got=%b want=0", underrun_o);
        end
    endtask

    task automatic test_underrun();
        bit ok;
        int k, bad;
        do_reset();
        fill(FW, 1'b1, '0, 1'b1);
        stall_at  = npops + 1;
        stall_len = STALL;
        next_line_rdy_i  = 1'b1;
        next_frame_rdy_i = 1'b1;
        k = 0;
        while (npops < stall_at && k < 50) begin
            step();
            k++;
        end
        repeat (STALL - 1) step();
        checks++;
        if (underrun_o !== 1'b0) begin
            failures++;
            $display("FAIL underrun_early got=%b want=0", underrun_o);
        end
        step();
        checks++;
        if (underrun_o !== 1'b1) begin
            failures++;
            $display("FAIL underrun_trip got=%b want=1", underrun_o);
        end
        run_beats(FW, 300, ok);
        checks++;
        if (!ok || underrun_o !== 1'b1) begin
            failures++;
            $display("FAIL underrun_line got=%b/%b want=1/1", ok, underrun_o);
        end
        fill(FW, 1'b1, '0, 1'b0);
        run_beats(2 * FW, 300, ok);
        bad = ok ? 0 : 1;
        for (int j = 0; j < beats.size(); j++)
            if (beats[j].d !== sent_q[j]) bad++;
        checks++;
        if (bad != 0 || underrun_o !== 1'b1) begin
            failures++;
            $display("FAIL underrun_frame2 got=%0d/%b want=0/1",
                     bad, underrun_o);
        end
        do_reset();
        checks++;
        if (underrun_o !== 1'b0) begin
            failures++;
            $display("FAIL underrun_clear got=%b want=0", underrun_o);
        end
    endtask

    task automatic test_line_hold();
        bit ok;
        int p0, oe_bad;
        do_reset();
        fill(FW, 1'b1, '0, 1'b1);
        next_line_rdy_i = 1'b1;
        start_frame();
        run_beats(1, 50, ok);
        next_line_rdy_i = 1'b0;
        run_beats(WPL, 50, ok);
        repeat (5) step();
        p0 = npops;
        oe_bad = 0;
        repeat (20) begin
            step();
            if (fifo_output_enable_o !== 1'b1 || busy_o !== 1'b1) oe_bad++;
        end
        checks++;
        if (oe_bad != 0 || npops != p0 || beats.size() != WPL) begin
            failures++;
            $display("FAIL hold_wait got=%0d/%0d/%0d want=0/%0d/%0d",
                     oe_bad, npops, beats.size(), p0, WPL);
        end
        checks++;
        if (line_count_o !== 2'd1) begin
            failures++;
            $display("FAIL hold_line got=%0d want=1", line_count_o);
        end
        next_line_rdy_i = 1'b1;
        step();
        checks++;
        if (beats.size() != WPL) begin
            failures++;
            $display("FAIL hold_early got=%0d want=%0d", beats.size(), WPL);
        end
        step();
        checks++;
        if (beats.size() != WPL + 1 || beats[WPL].ls !== 1'b1 ||
            beats[WPL].d !== sent_q[WPL]) begin
            failures++;
            $display("FAIL hold_resume got=%0d want=%0d", beats.size(), WPL + 1);
        end
        run_beats(FW, 200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL hold_finish got=%0d want=%0d", beats.size(), FW);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] ctl;
        do_reset();
        fill(FW, 1'b1, '0, 1'b1);
        next_line_rdy_i = 1'b1;
        start_frame();
        run_beats(WPL + 2, 100, ok);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        ctl = {fifo_output_enable_o, get_next_word_o, data_valid_o,
               line_start_o, line_end_o, frame_end_o, underrun_o, busy_o};
        checks++;
        if (ctl !== 8'h00 || data_o !== '0 || line_count_o !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_out got=%b/%h/%0d want=00000000/0/0",
                     ctl, data_o, line_count_o);
        end
        checks++;
        if (pop_reset != 0) begin
            failures++;
            $display("FAIL rstmid_pop got=%0d want=0", pop_reset);
        end
        fill(FW, 1'b1, '0, 1'b1);
        start_frame();
        run_beats(FW, 200, ok);
        checks++;
        if (!ok || beats[0].d !== sent_q[0] || beats[0].ls !== 1'b1 ||
            beats[0].lc !== 2'd0 || beats[FW-1].fe !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_restart got=%0d beats want=%0d", beats.size(), FW);
        end
    endtask

    task automatic test_no_frame();
        int act, p0;
        do_reset();
        fill(FW, 1'b1, '0, 1'b1);
        next_line_rdy_i = 1'b1;
        p0 = npops;
        act = 0;
        repeat (30) begin
            step();
            if (fifo_output_enable_o !== 1'b0 || busy_o !== 1'b0) act++;
        end
        checks++;
        if (act != 0 || npops != p0 || beats.size() != 0) begin
            failures++;
            $display("FAIL noframe got=%0d/%0d/%0d want=0/%0d/0",
                     act, npops, beats.size(), p0);
        end
    endtask

    task automatic test_random();
        bit ok;
        int k, bad;
        do_reset();
        fill(2 * FW, 1'b1, '0, 1'b1);
        rand_stall = 1'b1;
        next_frame_rdy_i = 1'b1;
        k = 0;
        while (beats.size() < 2 * FW && k < 3000) begin
            next_line_rdy_i = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        rand_stall = 1'b0;
        next_frame_rdy_i = 1'b0;
        ok = (beats.size() == 2 * FW);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rand_beats got=%0d want=%0d", beats.size(), 2 * FW);
        end
        bad = 0;
        for (int j = 0; j < beats.size(); j++) begin
            if ({beats[j].d, beats[j].ls, beats[j].le, beats[j].fe} !==
                {sent_q[j], ((j % WPL) == 0), ((j % WPL) == WPL - 1),
                 ((j % FW) == FW - 1)}) bad++;
            if (j % WPL == 0 && beats[j].lc !== 2'((j / WPL) % LPF)) bad++;
            if (j > 0 && j % WPL == 0 &&
                beats[j].cyc - beats[j-1].cyc < GAPC + 2) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rand_stream got=%0d bad want=0", bad);
        end
        checks++;
        if (underrun_o !== 1'b0) begin
            failures++;
            $display("FAIL rand_underrun got=%b want=0", underrun_o);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t limit=2000000", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame();
        test_short_stall();
        test_underrun();
        test_line_hold();
        test_reset_mid();
        test_no_frame();
        test_random();
        test_random();
        checks++;
        if (pop_no_oe != 0 || pop_empty != 0) begin
            failures++;
            $display("FAIL pop_rules got=%0d/%0d want=0/0", pop_no_oe, pop_empty);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
